onebyfour_demux_seq: RTL

Registered 1:4 demultiplexer and 4-lane frame collector: the receive-side counterpart to the transmission-gate 4:1 mux. It steers each accepted input word onto one of four lane registers (ya..yd), chosen by external {s1,s0} or by an internal round-robin pointer. It also assembles a 4-lane frame with a ready/valid handshake toward the consumer. It sits between a serialized link driven by the 4:1 mux and the parallel logic that consumes the lanes.

---
 rtl/onebyfour_demux_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/onebyfour_demux_seq.sv
// Registered 1:4 demultiplexer with 4-lane frame collector.
// Each accepted word goes to one lane register, chosen by {s1,s0} or by a round-robin pointer.
// Once all four lanes are written, the lanes are snapshotted into a frame.
// The frame is offered to the consumer with a ready/valid handshake.
module onebyfour_demux_seq #(
    parameter int unsigned W = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [W-1:0]   i_din,
    input  logic           i_din_valid,
    output logic           o_din_ready,
    input  logic           i_mode,
    input  logic           i_s1,
    input  logic           i_s0,
    output logic [W-1:0]   o_ya,
    output logic [W-1:0]   o_yb,
    output logic [W-1:0]   o_yc,
    output logic [W-1:0]   o_yd,
    output logic [3:0]     o_lane_valid,
    output logic [1:0]     o_sel_q,
    output logic [4*W-1:0] o_frame_data,
    output logic           o_frame_valid,
    input  logic           i_frame_ready,
    output logic           o_dup
);

    // Pointer states carry the select code of the lane they address.
    typedef enum logic [1:0] {
        StA = 2'b11,
        StB = 2'b01,
        StC = 2'b10,
        StD = 2'b00
    } ptr_e;

    ptr_e           r_ptr;
    ptr_e           w_ptr_cur;
    ptr_e           w_ptr_nxt;
    logic [W-1:0]   r_ya, r_yb, r_yc, r_yd;
    logic [W-1:0]   w_ya_d, w_yb_d, w_yc_d, w_yd_d;
    logic [3:0]     r_lane_valid;
    logic [1:0]     r_sel_q;
    logic [1:0]     w_sel_d;
    logic [4*W-1:0] r_frame_data;
    logic           r_frame_valid;
    logic           r_dup;
    logic [3:0]     r_mask;
    logic           r_mode_q;
    logic           w_din_ready;
    logic           w_acc;
    logic           w_mode_chg;
    logic [1:0]     w_code;
    logic [3:0]     w_lane_sel;
    logic [3:0]     w_mask_cur;
    logic [3:0]     w_mask_wr;
    logic           w_dup;
    logic           w_frame_done;

    assign w_din_ready = ~r_frame_valid | i_frame_ready;
    assign w_acc       = i_din_valid & w_din_ready;
    // A mode change restarts frame assembly before this cycle's write is applied.
    assign w_mode_chg  = i_mode ^ r_mode_q;
    assign w_ptr_cur   = w_mode_chg ? StA : r_ptr;
    assign w_mask_cur  = w_mode_chg ? 4'b0000 : r_mask;
    assign w_code      = i_mode ? w_ptr_cur : {i_s1, i_s0};

    // Pointer next state: advance round-robin only on an accepted auto-mode write.
    always_comb begin
        w_ptr_nxt = w_ptr_cur;
        if (i_mode && w_acc) begin
            unique case (w_ptr_cur)
                StA: w_ptr_nxt = StB;
                StB: w_ptr_nxt = StC;
                StC: w_ptr_nxt = StD;
                StD: w_ptr_nxt = StA;
            endcase
        end
    end

    // Decode select code to a one-hot lane mask (bit3 = ya ... bit0 = yd).
    always_comb begin
        w_lane_sel = 4'b0000;
        unique case (w_code)
            2'b11: w_lane_sel = 4'b1000;
            2'b01: w_lane_sel = 4'b0100;
            2'b10: w_lane_sel = 4'b0010;
            2'b00: w_lane_sel = 4'b0001;
        endcase
    end

    assign w_mask_wr    = w_mask_cur | (w_acc ? w_lane_sel : 4'b0000);
    assign w_dup        = w_acc & (|(w_mask_cur & w_lane_sel));
    assign w_frame_done = w_acc & (w_mask_wr == 4'b1111);

    assign w_ya_d = (w_acc & w_lane_sel[3]) ? i_din : r_ya;
    assign w_yb_d = (w_acc & w_lane_sel[2]) ? i_din : r_yb;
    assign w_yc_d = (w_acc & w_lane_sel[1]) ? i_din : r_yc;
    assign w_yd_d = (w_acc & w_lane_sel[0]) ? i_din : r_yd;

    // sel_q tracks the upcoming pointer in auto mode and the last applied code otherwise.
    assign w_sel_d = i_mode ? w_ptr_nxt : (w_acc ? {i_s1, i_s0} : r_sel_q);

    // Pointer state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= StA;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Lane, mask, frame and status registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ya          <= '0;
            r_yb          <= '0;
            r_yc          <= '0;
            r_yd          <= '0;
            r_lane_valid  <= 4'b0000;
            r_dup         <= 1'b0;
            r_mask        <= 4'b0000;
            r_sel_q       <= 2'b11;
            r_mode_q      <= 1'b0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_ya         <= w_ya_d;
            r_yb         <= w_yb_d;
            r_yc         <= w_yc_d;
            r_yd         <= w_yd_d;
            r_lane_valid <= w_acc ? w_lane_sel : 4'b0000;
            r_dup        <= w_dup;
            r_mask       <= w_frame_done ? 4'b0000 : w_mask_wr;
            r_sel_q      <= w_sel_d;
            r_mode_q     <= i_mode;
            if (w_frame_done) begin
                r_frame_data  <= {w_ya_d, w_yb_d, w_yc_d, w_yd_d};
                r_frame_valid <= 1'b1;
            end else if (i_frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign o_din_ready   = w_din_ready;
    assign o_ya          = r_ya;
    assign o_yb          = r_yb;
    assign o_yc          = r_yc;
    assign o_yd          = r_yd;
    assign o_lane_valid  = r_lane_valid;
    assign o_sel_q       = r_sel_q;
    assign o_frame_data  = r_frame_data;
    assign o_frame_valid = r_frame_valid;
    assign o_dup         = r_dup;

endmodule
